// File: rtl/rotated_pixel_frame_buffer.sv
// Single-frame IMG_DIM x IMG_DIM pixel store: filled row-major, read combinationally by {row,col}.
// Define ROT_FB_DOUBLE_BUFFER_EN for a two-bank ping-pong variant that keeps filling while a frame is held.
module rotated_pixel_frame_buffer #(
    parameter int IMG_DIM = 28,
    parameter int PIX_W   = 8,
    parameter int COORD_W = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_valid_i,
    input  logic [PIX_W-1:0]       wr_pixel_i,
    output logic                   wr_ready_o,
    input  logic [2*COORD_W-1:0]   rd_addr_i,
    output logic [PIX_W-1:0]       rd_data_o,
    output logic                   frame_ready_o,
    input  logic                   frame_done_i
);

    localparam logic [COORD_W-1:0] LAST_C = COORD_W'(IMG_DIM - 1);
    localparam logic [COORD_W:0]   DIM_C  = (COORD_W + 1)'(IMG_DIM);

`ifdef ROT_FB_DOUBLE_BUFFER_EN
    localparam int         NBANK   = 2;
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;
`else
    localparam int         NBANK    = 1;
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
`endif

    logic [PIX_W-1:0]   mem [NBANK][IMG_DIM][IMG_DIM];
    logic [0:0]         state_q;
    logic [COORD_W-1:0] wr_row_q;
    logic [COORD_W-1:0] wr_col_q;
    logic               wr_accept;
    logic               frame_last;
    logic               wr_bank;
    logic               rd_bank;
    logic [COORD_W-1:0] rd_row;
    logic [COORD_W-1:0] rd_col;
    logic               rd_in_range;

    assign wr_ready_o = (state_q == ST_FILL);
    assign wr_accept  = wr_valid_i && wr_ready_o;
    assign frame_last = wr_accept && (wr_row_q == LAST_C) && (wr_col_q == LAST_C);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_row_q <= '0;
            wr_col_q <= '0;
        end else if (wr_accept) begin
            if (wr_col_q == LAST_C) begin
                wr_col_q <= '0;
                if (wr_row_q == LAST_C) begin
                    wr_row_q <= '0;
                end else begin
                    wr_row_q <= wr_row_q + COORD_W'(1);
                end
            end else begin
                wr_col_q <= wr_col_q + COORD_W'(1);
            end
        end
    end

    // Pixel storage is deliberately left unreset; reads are gated by frame_ready_o instead.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[wr_bank][wr_row_q][wr_col_q] <= wr_pixel_i;
        end
    end

`ifdef ROT_FB_DOUBLE_BUFFER_EN
    logic bank_sel_q;
    logic frame_ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_FILL;
            bank_sel_q    <= 1'b0;
            frame_ready_q <= 1'b0;
        end else if (state_q == ST_FILL) begin
            if (frame_last) begin
                // A release on the completing edge frees the read bank just in time to swap.
                if (!frame_ready_q || frame_done_i) begin
                    bank_sel_q    <= ~bank_sel_q;
                    frame_ready_q <= 1'b1;
                end else begin
                    state_q <= ST_FULL;
                end
            end else if (frame_done_i) begin
                frame_ready_q <= 1'b0;
            end
        end else if (frame_done_i) begin
            bank_sel_q <= ~bank_sel_q;
            state_q    <= ST_FILL;
        end
    end

    assign wr_bank       = bank_sel_q;
    assign rd_bank       = ~bank_sel_q;
    assign frame_ready_o = frame_ready_q;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FILL;
        end else if (state_q == ST_FILL) begin
            if (frame_last) begin
                state_q <= ST_READY;
            end
        end else if (frame_done_i) begin
            state_q <= ST_FILL;
        end
    end

    assign wr_bank       = 1'b0;
    assign rd_bank       = 1'b0;
    assign frame_ready_o = (state_q == ST_READY);
`endif

    assign rd_row      = rd_addr_i[2*COORD_W-1:COORD_W];
    assign rd_col      = rd_addr_i[COORD_W-1:0];
    assign rd_in_range = ({1'b0, rd_row} < DIM_C) && ({1'b0, rd_col} < DIM_C);

    always_comb begin
        rd_data_o = '0;
        if (frame_ready_o && rd_in_range) begin
            rd_data_o = mem[rd_bank][rd_row][rd_col];
        end
    end

endmodule

// File: tb/tb_rotated_pixel_frame_buffer.sv
// Directed bench for rotated_pixel_frame_buffer; read expectations flow through a scoreboard queue.
// Build with ROT_FB_DOUBLE_BUFFER_EN defined to exercise the two-bank variant.
module tb_rotated_pixel_frame_buffer;

    localparam int IMG_DIM = 28;
    localparam int PIX_W   = 8;
    localparam int COORD_W = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 wr_valid;
    logic [PIX_W-1:0]     wr_pixel;
    logic                 wr_ready;
    logic [2*COORD_W-1:0] rd_addr;
    logic [PIX_W-1:0]     rd_data;
    logic                 frame_ready;
    logic                 frame_done;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    // Reference view of what the read port should expose.
    logic             rd_valid = 1'b0;
    int               rd_base  = 0;
    logic [PIX_W-1:0] exp_q[$];

    rotated_pixel_frame_buffer #(
        .IMG_DIM (IMG_DIM),
        .PIX_W   (PIX_W),
        .COORD_W (COORD_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wr_valid_i    (wr_valid),
        .wr_pixel_i    (wr_pixel),
        .wr_ready_o    (wr_ready),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .frame_ready_o (frame_ready),
        .frame_done_i  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams count pixels valued (index+base)&0xFF; checks frame_ready just before the last accept.
    task automatic stream(input int base, input int count, input logic exp_fr_pre, output int n_stall);
        n_stall = 0;
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            if (!wr_ready) n_stall++;
            if (i == count - 1) check("frame_ready_before_last", 32'(frame_ready), 32'(exp_fr_pre));
            wr_valid = 1'b1;
            wr_pixel = PIX_W'((i + base) & 255);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int r, input int c);
        logic [PIX_W-1:0] e;
        logic [PIX_W-1:0] got;
        e = (rd_valid && r < IMG_DIM && c < IMG_DIM) ? PIX_W'((r * IMG_DIM + c + rd_base) & 255) : '0;
        exp_q.push_back(e);
        rd_addr = {COORD_W'(r), COORD_W'(c)};
        #1;
        got = exp_q.pop_front();
        check(tag, 32'(rd_data), 32'(got));
    endtask

    task automatic done_pulse();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_valid   = 1'b0;
        wr_pixel   = '0;
        rd_addr    = '0;
        frame_done = 1'b0;
        #12;
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_frame_ready", 32'(frame_ready), 32'd0);
        read_chk("reset_read", 3, 7);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ROT_FB_DOUBLE_BUFFER_EN
        stream(0, IMG_DIM * IMG_DIM, 1'b0, stalls);
        check("frameA_stalls", 32'(stalls), 32'd0);
        check("frameA_wr_ready", 32'(wr_ready), 32'd1);
        check("frameA_frame_ready", 32'(frame_ready), 32'd1);
        rd_valid = 1'b1;
        rd_base  = 0;
        read_chk("frameA_rd_3_7", 3, 7);
        check("frameA_rd_3_7_const", 32'(rd_data), 32'd91);

        stream(50, IMG_DIM * IMG_DIM, 1'b1, stalls);
        check("frameB_stalls", 32'(stalls), 32'd0);
        check("frameB_full_wr_ready", 32'(wr_ready), 32'd0);
        check("frameB_full_frame_ready", 32'(frame_ready), 32'd1);
        read_chk("held_A_rd_3_7", 3, 7);
        read_chk("held_A_rd_27_27", 27, 27);

        done_pulse();
        check("swap_wr_ready", 32'(wr_ready), 32'd1);
        check("swap_frame_ready", 32'(frame_ready), 32'd1);
        rd_base = 50;
        read_chk("frameB_rd_3_7", 3, 7);
        check("frameB_rd_3_7_const", 32'(rd_data), 32'd141);
        read_chk("frameB_rd_0_0", 0, 0);
        read_chk("frameB_rd_oob", 2, 28);

        done_pulse();
        check("release_frame_ready", 32'(frame_ready), 32'd0);
        rd_valid = 1'b0;
        read_chk("release_read", 3, 7);
`else
        stream(0, IMG_DIM * IMG_DIM, 1'b0, stalls);
        check("frame1_stalls", 32'(stalls), 32'd0);
        check("frame1_wr_ready", 32'(wr_ready), 32'd0);
        check("frame1_frame_ready", 32'(frame_ready), 32'd1);
        rd_valid = 1'b1;
        rd_base  = 0;
        read_chk("frame1_rd_3_7", 3, 7);
        check("frame1_rd_3_7_const", 32'(rd_data), 32'd91);
        for (int k = 0; k < 6; k++) begin
            read_chk("frame1_rd_rand", int'($urandom_range(0, IMG_DIM - 1)), int'($urandom_range(0, IMG_DIM - 1)));
        end
        read_chk("oob_col_28", 2, 28);
        read_chk("oob_row_29", 29, 0);
        read_chk("oob_31_31", 31, 31);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ready_blocks_write", 32'(wr_ready), 32'd0);
            wr_valid = 1'b1;
            wr_pixel = 8'hAA;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        read_chk("ignored_write_0_0", 0, 0);
        read_chk("ignored_write_0_4", 0, 4);

        done_pulse();
        check("release_frame_ready", 32'(frame_ready), 32'd0);
        check("release_wr_ready", 32'(wr_ready), 32'd1);
        rd_valid = 1'b0;
        read_chk("release_read", 3, 7);

        done_pulse();
        check("done_in_fill_frame_ready", 32'(frame_ready), 32'd0);
        check("done_in_fill_wr_ready", 32'(wr_ready), 32'd1);

        stream(7, IMG_DIM * IMG_DIM, 1'b0, stalls);
        check("frame2_frame_ready", 32'(frame_ready), 32'd1);
        rd_valid = 1'b1;
        rd_base  = 7;
        read_chk("frame2_rd_0_0", 0, 0);
        read_chk("frame2_rd_27_27", 27, 27);
        check("frame2_rd_27_27_const", 32'(rd_data), 32'd22);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_frame_ready", 32'(frame_ready), 32'd0);
        check("async_reset_wr_ready", 32'(wr_ready), 32'd1);
        rd_valid = 1'b0;
        read_chk("async_reset_read", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        stream(8'h33, 100, 1'b0, stalls);
        check("partial_frame_ready", 32'(frame_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        stream(8'h11, IMG_DIM * IMG_DIM, 1'b0, stalls);
        check("frame3_frame_ready", 32'(frame_ready), 32'd1);
        rd_valid = 1'b1;
        rd_base  = 8'h11;
        read_chk("frame3_rd_0_0", 0, 0);
        read_chk("frame3_rd_3_7", 3, 7);
        read_chk("frame3_rd_3_17", 3, 17);
        read_chk("frame3_rd_27_27", 27, 27);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotated_pixel_frame_buffer.md
Name: rotated_pixel_frame_buffer

Overview:
- Responder side of the rotation datapath: a single-frame IMG_DIM x IMG_DIM pixel store.
- Filled by a row-major input pixel stream.
- Once full, it answers {row,col} address reads from the rotated address generator with zero-cycle (combinational) read data.
- Handshakes frame availability (frame_ready_o) and frame release (frame_done_i) with the consumer.

Parameters:
- IMG_DIM, 28, image width/height in pixels.
- PIX_W, 8, pixel width in bits.
- COORD_W, 5, width of one coordinate field; address width = 2*COORD_W.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- wr_valid_i  input  1  input stream pixel valid.
- wr_pixel_i  input  PIX_W  input stream pixel, row-major order.
- wr_ready_o  output  1  buffer accepts a pixel this cycle.
- rd_addr_i  input  2*COORD_W  read address {row[COORD_W-1:0], col[COORD_W-1:0]}.
- rd_data_o  output  PIX_W  pixel at rd_addr_i, combinational.
- frame_ready_o  output  1  complete frame held; reads valid.
- frame_done_i  input  1  consumer releases the held frame (1-cycle pulse).

Behaviour:
- Clock clk_i, single domain; reset rst_ni asynchronous, active-low.
- Reset values: state FILL; wr_row/wr_col = 0; wr_ready_o = 1; frame_ready_o = 0. Pixel array is not reset.
- States:
  - FILL: wr_ready_o = 1.
  - READY: wr_ready_o = 0, frame_ready_o = 1.
- Write accept: wr_valid_i && wr_ready_o at a rising edge stores wr_pixel_i at mem[wr_row][wr_col].
- Write counters:
  - wr_col increments on each accept; at IMG_DIM-1 it wraps to 0 and wr_row increments.
  - On accepting (IMG_DIM-1, IMG_DIM-1), the state becomes READY at that edge and both counters return to 0.
- wr_valid_i while wr_ready_o = 0: ignored; no write, no counter change.
- READY -> FILL on frame_done_i at an edge. frame_ready_o = 0 and wr_ready_o = 1 from the next cycle.
- frame_done_i in FILL: ignored.
- Read path:
  - rd_data_o = mem[row][col] combinationally when frame_ready_o = 1 and row < IMG_DIM and col < IMG_DIM.
  - Otherwise rd_data_o = 0. This covers any read while not READY and any out-of-range coordinate, e.g. col = 28..31.
  - Address 0 returns mem[0][0]; masking of address 0 is the requester's responsibility.
  - Latency 0: an address registered by the requester on edge N must be sampled valid on edge N+1.
- Reset mid-fill: partial frame discarded; counters 0, state FILL; stale array data is unreadable because frame_ready_o = 0.
- Reset mid-READY: frame_ready_o drops immediately (asynchronously).
- Arithmetic: counters unsigned, COORD_W bits; no other arithmetic.

Optional Feature:
- Macro: ROT_FB_DOUBLE_BUFFER_EN.
- Defined:
  - Two banks: a write bank and a read bank (bank select register, reset 0 = write bank 0). States: FILL, FULL.
  - Frame completion while the read bank is free (frame_ready_o = 0): banks swap at that edge, frame_ready_o = 1 next cycle, wr_ready_o stays 1, and filling continues into the other bank.
  - Frame completion while the read bank is held: state FULL, wr_ready_o = 0.
  - frame_done_i in FULL: swap at that edge; frame_ready_o stays 1 (new frame); state FILL, wr_ready_o = 1.
  - frame_done_i with no FULL pending: frame_ready_o = 0.
  - frame_done_i on the same edge as the last write: swap; frame_ready_o remains 1.
- Undefined: single-bank behaviour as above.

Test Plan:
- Stream 784 pixels, value (row*28+col) & 0xFF, wr_valid_i continuous -> wr_ready_o low and frame_ready_o high the cycle after the 784th accept; rd_addr_i = {5'd3,5'd7} gives rd_data_o = 91 the same cycle.
- READY, rd_addr_i = {5'd2,5'd28} and {5'd29,5'd0} -> rd_data_o = 0; before the frame completes, any address -> 0.
- READY, wr_valid_i = 1 with pixel 0xAA for 5 cycles -> no change; {5'd0,5'd0} still reads 0x00.
- frame_done_i pulse in READY -> next cycle frame_ready_o = 0, wr_ready_o = 1; the next pixel lands at (0,0). frame_done_i pulse in FILL -> no effect.
- Reset asserted after 100 accepts, then a full 784-pixel frame -> frame_ready_o only after the 784th post-reset pixel, and data matches the post-reset stream.
- ROT_FB_DOUBLE_BUFFER_EN:
  - Frame A completes, then frame B streams without stall -> wr_ready_o stays 1.
  - B completes with no frame_done_i -> wr_ready_o = 0, reads still return A.
  - frame_done_i -> reads return B next cycle, wr_ready_o = 1.
